// File: rtl/atm_counter_reader_pkg.sv
// Shared definitions for the 64-bit atomic counter reader and its responder:
// bus widths, word-select encoding and the reader FSM state encoding.
package atm_counter_reader_pkg;

    localparam int CNT_W = 32;
    localparam int VAL_W = 64;

    // Word select carried on atomic_o alongside req_o.
    localparam logic SEL_LO = 1'b1;
    localparam logic SEL_HI = 1'b0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_REQ_HI1  = 3'd1;
    localparam state_t ST_WAIT_HI1 = 3'd2;
    localparam state_t ST_REQ_LO   = 3'd3;
    localparam state_t ST_WAIT_LO  = 3'd4;
    localparam state_t ST_REQ_HI2  = 3'd5;
    localparam state_t ST_WAIT_HI2 = 3'd6;

    function automatic logic [1:0] sat_retries(input logic [7:0] n);
        return (n > 8'd3) ? 2'd3 : n[1:0];
    endfunction

endpackage

// File: rtl/atm_counter_reader_if.sv
// Read port between the snapshot reader (master) and the counter responder (slave).
// Handshake: req_o is a one-cycle request with atomic_o selecting the word; the
// responder answers with ack_i high for one cycle, count_i valid only while ack_i=1.
interface atm_counter_reader_if;
    import atm_counter_reader_pkg::*;

    logic             req_o;
    logic             atomic_o;
    logic             ack_i;
    logic [CNT_W-1:0] count_i;

    modport master (output req_o, output atomic_o, input ack_i, input count_i);
    modport slave  (input req_o, input atomic_o, output ack_i, output count_i);

endinterface

// File: rtl/atm_counter_reader_ack_timeout_cnt.sv
// Loadable down-counter that flags when ACK_TIMEOUT wait cycles have elapsed
// without an acknowledge.
module ack_timeout_cnt #(
    parameter int ACK_TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(ACK_TIMEOUT + 1);
    // Loaded with N-1 so expiry lands on the N-th wait cycle.
    localparam logic [W-1:0] LOAD_VAL = W'(ACK_TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = en && (count == '0);

endmodule

// File: rtl/atm_counter_reader.sv
// Tear-free 64-bit snapshot of the atomic event counter using a high/low/high
// read sequence over the 32-bit read port, with bounded retries and ack timeout.
module atm_counter_reader
    import atm_counter_reader_pkg::*;
#(
    parameter int ACK_TIMEOUT = 8,
    parameter int MAX_RETRY   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    atm_counter_reader_if.master         bus,
    output logic                         busy_o,
    output logic                         valid_o,
    output logic [VAL_W-1:0]             value_o,
    output logic [1:0]                   retries_o,
    output logic                         err_o,
    output logic [2:0]                   fsm_state
);

    localparam logic [7:0] MAX_R = 8'(MAX_RETRY);

    state_t           state;
    logic [CNT_W-1:0] hi1;
    logic [CNT_W-1:0] lo;
    logic [7:0]       retry_cnt;
    logic             in_req;
    logic             in_wait;
    logic             timed_out;
    logic             accept;

    assign in_req  = (state == ST_REQ_HI1) || (state == ST_REQ_LO) || (state == ST_REQ_HI2);
    assign in_wait = (state == ST_WAIT_HI1) || (state == ST_WAIT_LO) || (state == ST_WAIT_HI2);

    // A start landing on the completion pulse is dropped, not queued.
    assign accept = (state == ST_IDLE) && start_i && !valid_o && !err_o;

    ack_timeout_cnt #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (in_req),
        .en      (in_wait),
        .expired (timed_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hi1       <= '0;
            lo        <= '0;
            retry_cnt <= '0;
            value_o   <= '0;
            retries_o <= '0;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        retry_cnt <= '0;
                        state     <= ST_REQ_HI1;
                    end
                end
                ST_REQ_HI1: state <= ST_WAIT_HI1;
                ST_WAIT_HI1: begin
                    if (bus.ack_i) begin
                        hi1   <= bus.count_i;
                        state <= ST_REQ_LO;
                    end else if (timed_out) begin
                        err_o     <= 1'b1;
                        retries_o <= sat_retries(retry_cnt);
                        state     <= ST_IDLE;
                    end
                end
                ST_REQ_LO: state <= ST_WAIT_LO;
                ST_WAIT_LO: begin
                    if (bus.ack_i) begin
                        lo    <= bus.count_i;
                        state <= ST_REQ_HI2;
                    end else if (timed_out) begin
                        err_o     <= 1'b1;
                        retries_o <= sat_retries(retry_cnt);
                        state     <= ST_IDLE;
                    end
                end
                ST_REQ_HI2: state <= ST_WAIT_HI2;
                ST_WAIT_HI2: begin
                    if (bus.ack_i) begin
                        if (bus.count_i == hi1) begin
                            value_o   <= {bus.count_i, lo};
                            valid_o   <= 1'b1;
                            retries_o <= sat_retries(retry_cnt);
                            state     <= ST_IDLE;
                        end else if (retry_cnt < MAX_R) begin
                            // High word moved: the new high becomes the reference, re-read low only.
                            retry_cnt <= retry_cnt + 8'd1;
                            hi1       <= bus.count_i;
                            state     <= ST_REQ_LO;
                        end else begin
                            err_o     <= 1'b1;
                            retries_o <= sat_retries(retry_cnt);
                            state     <= ST_IDLE;
                        end
                    end else if (timed_out) begin
                        err_o     <= 1'b1;
                        retries_o <= sat_retries(retry_cnt);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_o    = in_req;
    assign bus.atomic_o = (state == ST_REQ_LO) ? SEL_LO : SEL_HI;
    assign busy_o       = (state != ST_IDLE) || valid_o || err_o;
    assign fsm_state    = state;

endmodule

// File: tb/tb_atm_counter_reader.sv
// Bench for atm_counter_reader: directed and randomized snapshots against a
// counter responder model and a read-sequence reference model.
module tb_atm_counter_reader;
    import atm_counter_reader_pkg::*;

    localparam int ACK_TO = 8;
    localparam int MAX_R  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        busy_o;
    logic        valid_o;
    logic [63:0] value_o;
    logic [1:0]  retries_o;
    logic        err_o;
    logic [2:0]  fsm_state;

    atm_counter_reader_if bus ();

    atm_counter_reader #(
        .ACK_TIMEOUT(ACK_TO),
        .MAX_RETRY  (MAX_R)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .bus       (bus.master),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .value_o   (value_o),
        .retries_o (retries_o),
        .err_o     (err_o),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counter responder model ----------------
    logic [63:0] r_cnt   = '0;
    logic [63:0] r_step  = '0;
    int          r_bumps = 0;
    bit          r_en    = 1'b1;
    bit          r_force = 1'b0;
    bit          r_pend  = 1'b0;
    logic [31:0] r_word  = '0;

    initial begin
        bus.ack_i   = 1'b0;
        bus.count_i = '0;
    end

    // Samples req mid-cycle and answers during the following cycle.
    always @(negedge clk) begin
        bus.ack_i = 1'b0;
        if ((r_pend && r_en) || r_force) begin
            bus.ack_i   = 1'b1;
            bus.count_i = r_word;
        end
        r_force = 1'b0;
        r_pend  = 1'b0;
        if (bus.req_o === 1'b1) begin
            r_pend = 1'b1;
            r_word = (bus.atomic_o == SEL_LO) ? r_cnt[31:0] : r_cnt[63:32];
            if (r_bumps > 0) begin
                r_cnt   = r_cnt + r_step;
                r_bumps = r_bumps - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_val = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_valid_value(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_valid"}, 64'(valid_o), 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sb_value"}, value_o, e);
        end
    endtask

    // ---------------- driver: one snapshot with model prediction ----------------
    task automatic run_snap(input logic [63:0] c0, input logic [63:0] step,
                            input int bumps, input bit acks, input string tag);
        logic [31:0] w[16];
        logic [63:0] c;
        logic [63:0] exp_val;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] hi2;
        int          b;
        int          idx;
        int          ret;
        int          n_reads;
        int          done;
        int          seen_req;
        int          early;
        bit          exp_ok;
        bit          exp_err;

        // Words the responder will return for read 0,1,2,...: high, low, high, low, ...
        c = c0;
        b = bumps;
        for (int i = 0; i < 16; i++) begin
            w[i] = (i % 2 == 1) ? c[31:0] : c[63:32];
            if (b > 0) begin
                c = c + step;
                b--;
            end
        end

        exp_ok  = 1'b0;
        exp_err = 1'b0;
        exp_val = '0;
        ret     = 0;
        if (!acks) begin
            n_reads = 1;
            exp_err = 1'b1;
            done    = 1 + ACK_TO + 1;
        end else begin
            hi  = w[0];
            idx = 1;
            for (int a = 0; a <= MAX_R; a++) begin
                lo  = w[idx];
                hi2 = w[idx + 1];
                idx += 2;
                if (hi2 == hi) begin
                    exp_ok  = 1'b1;
                    exp_val = {hi2, lo};
                    break;
                end
                if (a == MAX_R) begin
                    exp_err = 1'b1;
                    break;
                end
                ret++;
                hi = hi2;
            end
            n_reads = idx;
            done    = 2 * n_reads + 1;
        end
        if (exp_ok) begin
            model_val = exp_val;
            exp_q.push_back(exp_val);
        end

        @(posedge clk);
        #1;
        r_cnt   = c0;
        r_step  = step;
        r_bumps = bumps;
        r_en    = acks;
        r_pend  = 1'b0;

        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;

        seen_req = 0;
        early    = 0;
        for (int k = 1; k <= done + 1; k++) begin
            @(negedge clk);
            if (bus.req_o === 1'b1) begin
                chk({tag, "_req_cycle"}, 64'(k), 64'(1 + 2 * seen_req));
                chk({tag, "_atomic"}, 64'(bus.atomic_o), 64'((seen_req % 2 == 1) ? SEL_LO : SEL_HI));
                seen_req++;
            end
            if (valid_o === 1'b1) chk_valid_value(tag);
            if (k < done && (valid_o || err_o)) early++;
            if (k == done) begin
                chk({tag, "_valid"},   64'(valid_o),   64'(exp_ok));
                chk({tag, "_err"},     64'(err_o),     64'(exp_err));
                chk({tag, "_busy_end"}, 64'(busy_o),   64'd1);
                chk({tag, "_retries"}, 64'(retries_o), 64'((ret > 3) ? 3 : ret));
                chk({tag, "_value"},   value_o,        model_val);
            end
            if (k == done + 1) begin
                chk({tag, "_busy_after"}, 64'(busy_o),    64'd0);
                chk({tag, "_idle"},       64'(fsm_state), 64'(ST_IDLE));
            end
        end
        chk({tag, "_early_pulse"}, 64'(early), 64'd0);
        chk({tag, "_num_req"}, 64'(seen_req), 64'(n_reads));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          nv;
        logic [63:0] rc;
        logic [63:0] rs;
        int          sel;

        rst     = 1'b1;
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req",     64'(bus.req_o),    64'd0);
        chk("rst_atomic",  64'(bus.atomic_o), 64'd0);
        chk("rst_busy",    64'(busy_o),       64'd0);
        chk("rst_valid",   64'(valid_o),      64'd0);
        chk("rst_err",     64'(err_o),        64'd0);
        chk("rst_value",   value_o,           64'd0);
        chk("rst_retries", 64'(retries_o),    64'd0);
        rst = 1'b0;

        run_snap(64'h0000_0001_FFFF_FFF0, 64'd0, 0, 1'b1, "nominal");
        run_snap(64'h0000_0000_FFFF_FFFF, 64'd1, 1, 1'b1, "one_retry");
        run_snap(64'h0000_0005_0000_0000, 64'h1_0000_0000, 100, 1'b1, "retry_exhaust");
        run_snap(64'h1234_5678_9ABC_DEF0, 64'd0, 0, 1'b0, "timeout");

        for (int i = 0; i < 12; i++) begin
            rc = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) rc[31:4] = '1;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rs = 64'd0;
                1:       rs = 64'($urandom_range(1, 5));
                2:       rs = 64'h1_0000_0000;
                default: rs = {$urandom, $urandom};
            endcase
            run_snap(rc, rs, $urandom_range(0, 6), ($urandom_range(0, 7) != 0), $sformatf("rand%0d", i));
        end

        // start held across two complete snapshots
        @(posedge clk);
        #1;
        r_cnt   = 64'hCAFE_0000_0000_BEEF;
        r_step  = '0;
        r_bumps = 0;
        r_en    = 1'b1;
        r_pend  = 1'b0;
        model_val = 64'hCAFE_0000_0000_BEEF;
        exp_q.push_back(model_val);
        exp_q.push_back(model_val);
        nv = 0;
        @(negedge clk);
        start_i = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 16) start_i = 1'b0;
            if (valid_o === 1'b1) begin
                nv++;
                chk_valid_value("hold");
            end
            if (k == 7 || k == 15) chk($sformatf("hold_valid_c%0d", k), 64'(valid_o), 64'd1);
            if (k == 8) chk("hold_busy_gap", 64'(busy_o), 64'd0);
            if (k == 9) chk("hold_busy_restart", 64'(busy_o), 64'd1);
        end
        chk("hold_snapshots", 64'(nv), 64'd2);

        // reset in WAIT_LO, then a stray ack
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_state_wait_lo", 64'(fsm_state), 64'(ST_WAIT_LO));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req",     64'(bus.req_o), 64'd0);
        chk("mid_rst_busy",    64'(busy_o),    64'd0);
        chk("mid_rst_value",   value_o,        64'd0);
        chk("mid_rst_valid",   64'(valid_o),   64'd0);
        chk("mid_rst_retries", 64'(retries_o), 64'd0);
        rst = 1'b0;
        model_val = '0;
        @(posedge clk);
        #1 r_force = 1'b1;
        nv = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (valid_o || err_o || busy_o || bus.req_o) nv++;
        end
        chk("late_ack_ignored", 64'(nv), 64'd0);
        chk("late_ack_value", value_o, model_val);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
